// File: rtl/wb_hyperram_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of a single wb_hyperram slave.
// Optional grant watchdog is compiled in with `define WB_HYPERRAM_ARB_TIMEOUT_EN.
module wb_hyperram_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 200
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  output logic [1:0]  grant_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 2..255");
  end

  state_t state;
  logic   last_grant;
  logic   req0;
  logic   req1;
  logic   tmo_hit;

  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;

`ifdef WB_HYPERRAM_ARB_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] tmo_cnt;
  logic       timeout_q;

  assign tmo_hit   = (state != IDLE) && (tmo_cnt == TIMEOUT_LAST) && !s_ack_i;
  assign timeout_o = timeout_q;

  // Counter is held at zero in IDLE, so every grant starts counting from 0.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      tmo_cnt   <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      if (state == IDLE)
        tmo_cnt <= 8'd0;
      else if (!s_ack_i)
        tmo_cnt <= tmo_cnt + 8'd1;
      if (tmo_hit)
        timeout_q <= 1'b1;
    end
  end
`else
  assign tmo_hit   = 1'b0;
  assign timeout_o = 1'b0;
`endif

  // Data path: the owner's signals pass straight through; everyone else sees zeros.
  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = 4'h0;
    s_addr_o = 32'h0;
    s_dat_o  = 32'h0;
    m0_ack_o = 1'b0;
    m0_dat_o = 32'h0;
    m1_ack_o = 1'b0;
    m1_dat_o = 32'h0;
    case (state)
      GRANT0: begin
        s_cyc_o  = m0_cyc_i & ~tmo_hit;
        s_stb_o  = m0_stb_i & ~tmo_hit;
        s_we_o   = m0_we_i;
        s_sel_o  = m0_sel_i;
        s_addr_o = m0_addr_i;
        s_dat_o  = m0_dat_i;
        m0_ack_o = s_ack_i | tmo_hit;
        m0_dat_o = tmo_hit ? TIMEOUT_DATA : s_dat_i;
      end
      GRANT1: begin
        s_cyc_o  = m1_cyc_i & ~tmo_hit;
        s_stb_o  = m1_stb_i & ~tmo_hit;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        s_addr_o = m1_addr_i;
        s_dat_o  = m1_dat_i;
        m1_ack_o = s_ack_i | tmo_hit;
        m1_dat_o = tmo_hit ? TIMEOUT_DATA : s_dat_i;
      end
      default: ;
    endcase
  end

  // One transfer per grant: ack, abort or watchdog always drops back to IDLE.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      grant_o    <= 2'b00;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req0 && (!req1 || last_grant)) begin
            state      <= GRANT0;
            grant_o    <= 2'b01;
            last_grant <= 1'b0;
          end else if (req1) begin
            state      <= GRANT1;
            grant_o    <= 2'b10;
            last_grant <= 1'b1;
          end
        end
        GRANT0: begin
          if (s_ack_i || !m0_cyc_i || tmo_hit) begin
            state   <= IDLE;
            grant_o <= 2'b00;
          end
        end
        GRANT1: begin
          if (s_ack_i || !m1_cyc_i || tmo_hit) begin
            state   <= IDLE;
            grant_o <= 2'b00;
          end
        end
        default: begin
          state   <= IDLE;
          grant_o <= 2'b00;
        end
      endcase
    end
  end

endmodule
